// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Config fields are held at 32 bits so any counter width up to 32 fits one struct type.
package clk_div_pkg;

  localparam int unsigned DIV_MIN   = 2;
  localparam int unsigned CFG_W_MAX = 32;

  typedef struct packed {
    logic [CFG_W_MAX-1:0] div;
    logic [CFG_W_MAX-1:0] high;
  } cfg_t;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active and shadow ratio/high-time, and pending flag.
// Shadow values take effect only at a period boundary or on sync, so periods never truncate.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CntW       = 16,
  parameter int unsigned DefaultDiv = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic sync_i,
  input  logic wr_i,
  input  cfg_t cfg_i,
  output logic pending_o,
  output logic clk_out_o,
  output logic tick_o
);

  localparam cfg_t ResetCfg = '{div:  CFG_W_MAX'(DefaultDiv),
                                high: CFG_W_MAX'(DefaultDiv / 2)};

  logic [CntW-1:0]      cnt_q, cnt_d;
  cfg_t                 act_q, act_d;
  cfg_t                 shd_q, shd_d;
  logic                 pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;

  logic [CFG_W_MAX-1:0] cnt_ext;
  logic [CFG_W_MAX-1:0] div_eff;
  logic                 wrap;
  logic                 level;

  assign cnt_ext = CFG_W_MAX'(cnt_q);
  assign div_eff = (act_q.div < CFG_W_MAX'(DIV_MIN)) ? CFG_W_MAX'(DIV_MIN) : act_q.div;
  assign wrap    = (cnt_ext == div_eff - CFG_W_MAX'(1));

  // high==0 forces low; high>=div (raw, before clamping) forces high.
  assign level = (act_q.high != '0) &&
                 ((act_q.high >= act_q.div) || (cnt_ext < act_q.high));

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;

    if (wr_i) begin
      shd_d  = cfg_i;
      pend_d = 1'b1;
    end

    if (sync_i) begin
      cnt_d = '0;
      if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else if (en_i) begin
      clk_d = level;
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      act_q  <= ResetCfg;
      shd_q  <= ResetCfg;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pending_o = pend_q;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config decode, ready mux and channel array.
// Define CLKDIV_SYNC_EN to add sync_req_i, which phase-aligns all channels at once.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int unsigned N_CH        = 4,
  parameter  int unsigned CNT_W       = 16,
  parameter  int unsigned DEFAULT_DIV = 50,
  localparam int unsigned CH_W        = ch_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_req_i,
`endif
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic [CNT_W-1:0] cfg_high_i,
  output logic [N_CH-1:0]  clk_out_o,
  output logic [N_CH-1:0]  tick_o
);

  localparam int unsigned PadN = 1 << CH_W;

  logic [N_CH-1:0] pending;
  logic [PadN-1:0] pending_pad;
  logic            cfg_fire;
  logic            sync;
  cfg_t            cfg_wr;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_req_i;
`else
  assign sync = 1'b0;
`endif

  // Unused channel slots read as not pending, so out-of-range writes are accepted and dropped.
  assign pending_pad = PadN'(pending);
  assign cfg_ready_o = !pending_pad[cfg_ch_i];
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;
  assign cfg_wr      = '{div: CFG_W_MAX'(cfg_div_i), high: CFG_W_MAX'(cfg_high_i)};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_fire && (cfg_ch_i == CH_W'(i));

    clk_div_channel #(
      .CntW       (CNT_W),
      .DefaultDiv (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en_i),
      .sync_i    (sync),
      .wr_i      (wr),
      .cfg_i     (cfg_wr),
      .pending_o (pending[i]),
      .clk_out_o (clk_out_o[i]),
      .tick_o    (tick_o[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with three channels (exercises an out-of-range channel id).
module tb_clk_div_multi;

  localparam int unsigned NCh  = 3;
  localparam int unsigned CntW = 16;
  localparam int unsigned ChW  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [ChW-1:0]  cfg_ch = '0;
  logic [CntW-1:0] cfg_div = '0;
  logic [CntW-1:0] cfg_high = '0;
  logic [NCh-1:0]  clk_out;
  logic [NCh-1:0]  tick;
`ifdef CLKDIV_SYNC_EN
  logic            sync_req = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int n = 0;

  clk_div_multi #(
    .N_CH        (NCh),
    .CNT_W       (CntW),
    .DEFAULT_DIV (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
`ifdef CLKDIV_SYNC_EN
    .sync_req_i  (sync_req),
`endif
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_div_i   (cfg_div),
    .cfg_high_i  (cfg_high),
    .clk_out_o   (clk_out),
    .tick_o      (tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b0;
    step();
    step();
    checks++;
    if (tick !== 3'b000) begin
      errors++;
      $display("FAIL reset_tick got %b exp 000", tick);
    end
    checks++;
    if (clk_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_clk_out got %b exp 000", clk_out);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", cfg_ready);
    end
  endtask

  task automatic test_default();
    rst = 1'b1;
    en  = 1'b1;
    n   = 0;
    for (int k = 0; k < 150; k++) begin
      logic [2:0] et, ec;
      step();
      et = (n % 50 == 0) ? 3'b111 : 3'b000;
      ec = (((n - 1) % 50) < 25) ? 3'b111 : 3'b000;
      checks++;
      if ({tick, clk_out} !== {et, ec}) begin
        errors++;
        $display("FAIL default n=%0d tick/clk got %b/%b exp %b/%b", n, tick, clk_out, et, ec);
      end
    end
  endtask

  task automatic test_write_ch1();
    while (n < 160) step();
    cfg_ch    = 2'd1;
    cfg_div   = 16'd10;
    cfg_high  = 16'd3;
    cfg_valid = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr1_ready_idle got %b exp 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 70; k++) begin
      logic et, ec, er;
      if (k > 0) step();
      if (n <= 200) begin
        et = (n == 200);
        ec = (((n - 1) % 50) < 25);
      end else begin
        et = ((n - 200) % 10 == 0);
        ec = (((n - 201) % 10) < 3);
      end
      er = (n >= 200);
      checks++;
      if ({tick[1], clk_out[1], cfg_ready} !== {et, ec, er}) begin
        errors++;
        $display("FAIL wr1 n=%0d tick/clk/ready got %b%b%b exp %b%b%b",
                 n, tick[1], clk_out[1], cfg_ready, et, ec, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    cfg_div   = 16'd6;
    cfg_high  = 16'd2;
    cfg_valid = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ready got %b exp 1", cfg_ready);
    end
    step();
    cfg_div  = 16'd8;
    cfg_high = 16'd4;
    for (int k = 0; k < 10; k++) begin
      logic et, ec, er;
      if (k > 0) step();
      et = (n == 240);
      ec = (((n - 201) % 10) < 3);
      er = (n == 240);
      checks++;
      if ({tick[1], clk_out[1], cfg_ready} !== {et, ec, er}) begin
        errors++;
        $display("FAIL b2b_stall n=%0d tick/clk/ready got %b%b%b exp %b%b%b",
                 n, tick[1], clk_out[1], cfg_ready, et, ec, er);
      end
    end
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 22; k++) begin
      logic et, ec, er;
      if (k > 0) step();
      if (n <= 246) begin
        et = (n == 246);
        ec = ((n - 241) < 2);
      end else begin
        et = ((n - 246) % 8 == 0);
        ec = (((n - 247) % 8) < 4);
      end
      er = (n >= 246);
      checks++;
      if ({tick[1], clk_out[1], cfg_ready} !== {et, ec, er}) begin
        errors++;
        $display("FAIL b2b_run n=%0d tick/clk/ready got %b%b%b exp %b%b%b",
                 n, tick[1], clk_out[1], cfg_ready, et, ec, er);
      end
    end
  endtask

  task automatic test_clamp();
    cfg_ch    = 2'd2;
    cfg_div   = 16'd1;
    cfg_high  = 16'd0;
    cfg_valid = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL clamp_ready got %b exp 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    while (n < 310) begin
      logic et, ec, er;
      step();
      if (n <= 300) begin
        et = (n == 300);
        ec = (((n - 1) % 50) < 25);
      end else begin
        et = ((n - 300) % 2 == 0);
        ec = 1'b0;
      end
      er = (n >= 300);
      checks++;
      if ({tick[2], clk_out[2], cfg_ready} !== {et, ec, er}) begin
        errors++;
        $display("FAIL clamp_div1 n=%0d tick/clk/ready got %b%b%b exp %b%b%b",
                 n, tick[2], clk_out[2], cfg_ready, et, ec, er);
      end
    end
    cfg_div   = 16'd5;
    cfg_high  = 16'd7;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    checks++;
    if (tick[2] !== 1'b1) begin
      errors++;
      $display("FAIL clamp_reload_tick got %b exp 1", tick[2]);
    end
    while (n < 330) begin
      logic et;
      step();
      et = ((n - 312) % 5 == 0);
      checks++;
      if ({tick[2], clk_out[2]} !== {et, 1'b1}) begin
        errors++;
        $display("FAIL clamp_high n=%0d tick/clk got %b%b exp %b1", n, tick[2], clk_out[2], et);
      end
    end
  endtask

  task automatic test_en_gap();
    en = 1'b0;
    for (int k = 0; k < 13; k++) begin
      step();
      checks++;
      if ({tick, clk_out[0], clk_out[2]} !== 5'b00001) begin
        errors++;
        $display("FAIL en_gap n=%0d tick/clk0/clk2 got %b/%b/%b exp 000/0/1",
                 n, tick, clk_out[0], clk_out[2]);
      end
    end
    en = 1'b1;
    while (n < 420) begin
      logic et, ec;
      step();
      et = ((n - 13) % 50 == 0);
      ec = (((n - 14) % 50) < 25);
      checks++;
      if ({tick[0], clk_out[0]} !== {et, ec}) begin
        errors++;
        $display("FAIL en_resume n=%0d tick/clk got %b%b exp %b%b", n, tick[0], clk_out[0], et, ec);
      end
    end
  endtask

  task automatic test_out_of_range();
    cfg_ch    = 2'd3;
    cfg_div   = 16'd4;
    cfg_high  = 16'd1;
    cfg_valid = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_ready got %b exp 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_ready_after got %b exp 1", cfg_ready);
    end
    while (n < 463) begin
      logic et;
      step();
      et = ((n - 13) % 50 == 0);
      checks++;
      if (tick[0] !== et) begin
        errors++;
        $display("FAIL oor_ch0 n=%0d tick got %b exp %b", n, tick[0], et);
      end
    end
  endtask

  task automatic test_reset_pending();
    cfg_ch    = 2'd0;
    cfg_div   = 16'd10;
    cfg_high  = 16'd5;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstp_pending_ready got %b exp 0", cfg_ready);
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({tick, clk_out, cfg_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL rstp_reset tick/clk/ready got %b/%b/%b exp 000/000/1",
               tick, clk_out, cfg_ready);
    end
    rst = 1'b1;
    n   = 0;
    for (int k = 0; k < 60; k++) begin
      logic [2:0] et;
      logic       ec;
      step();
      et = (n == 50) ? 3'b111 : 3'b000;
      ec = (((n - 1) % 50) < 25);
      checks++;
      if ({tick, clk_out[0]} !== {et, ec}) begin
        errors++;
        $display("FAIL rstp_run n=%0d tick/clk0 got %b/%b exp %b/%b", n, tick, clk_out[0], et, ec);
      end
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      logic [2:0] et;
      step();
      et = (n == 50) ? 3'b111 : 3'b000;
      checks++;
      if (tick !== et) begin
        errors++;
        $display("FAIL sync n=%0d tick got %b exp %b", n, tick, et);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_write_ch1();
    test_back_to_back();
    test_clamp();
    test_en_gap();
    test_out_of_range();
    test_reset_pending();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
